d_latch_q4: RTL and testbench
=============================

Name: d_latch_q4

Overview:
- Level-sensitive (transparent-high) D latch with complementary outputs q/qbar.
- Adds an asynchronous active-low clear.
- Structured as a gated NAND SR-latch core, width-parameterised so one instance can hold a bus.
- Sits as a storage primitive in small sequential datapaths; the clock input acts as the latch enable.

Parameters:
- WIDTH, 1, number of independent latch bits; d/q/qbar are WIDTH wide.
- TPD, 0, simulation-only propagation delay in ns from any input change to q/qbar; ignored by synthesis.

Ports:
- clk  input  1  latch enable; transparent while 1, opaque while 0.
- rst_n  input  1  asynchronous active-low clear.
- d  input  WIDTH  data input.
- q  output  WIDTH  latched data.
- qbar  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n=0 forces q=0 and qbar=all-ones immediately, independent of clk and d.
  - Reset dominates transparency: clk=1 during reset has no effect.
- Reset release:
  - rst_n 0→1 while clk=1: q takes the current d after TPD.
  - rst_n 0→1 while clk=0: q stays 0 until clk next goes high.
- Transparent phase (clk=1, rst_n=1): q follows d combinationally after TPD. Every d change inside the phase propagates; no edge sampling.
- Opaque phase (clk=0, rst_n=1): q holds the value of d present at the clk 1→0 transition. d changes are ignored.
- Entering transparency (clk 0→1): q updates to the current d at once. No cycle of latency.
- Simultaneous d change and clk falling edge:
  - The pre-change d value is captured (hold time treated as 0).
  - The bench must not check q at that exact instant.
- Simultaneous d change and clk rising edge: q ends at the new d.
- Output relation: qbar == ~q at all times after TPD settles, including during reset. The outputs never show q == qbar in steady state.
- Power-up before any reset: q is X. The first rst_n assertion defines the state.
- X on d during transparency propagates to q. X on d during the opaque phase is ignored.
- All bits are independent; there is no cross-bit interaction.

Decomposition:
- Shared package d_latch_q4_pkg holds:
  - the default WIDTH;
  - the reset values (Q_RST = '0, QBAR_RST = '1).
- Natural sub-module: sr_latch_nand.
  - One bit of cross-coupled NAND pair with active-low set/reset.
  - Instantiated WIDTH times via generate.
  - The top gates d and ~d with clk and merges rst_n into the reset leg.
- A behavioural always_latch implementation is equally acceptable, provided the port-level behaviour above is met.

Test Plan:
- Reset: rst_n=0 with clk toggling every 60 ns and d=1 → q=0, qbar=1 throughout. Release rst_n at a clk-low time → q stays 0 until the next clk rise.
- Opaque hold: clk period 120 ns (high 60–120, 180–240, …), d 0→1 at t=150 while clk=0 → q stays 0 until t=180, then q=1, qbar=0.
- Rising-edge coincidence: d 1→0 exactly at t=300 when clk rises → q=0 from t=300 and held through the 360–420 low phase.
- Transparent follow: d 0→1 at t=450 while clk=1 (420–480) → q=1 immediately. Toggling d 1→0→1 within the high phase → q tracks each change.
- Mid-phase reset: assert rst_n=0 at t=470 while clk=1, d=1 → q=0 at once. Deassert at t=475 → q returns to 1 (still transparent).
- WIDTH=8: d=8'hA5 during clk high, then d=8'h3C after clk falls → q=8'hA5, qbar=8'h5A held until the next clk high, then q=8'h3C.

Source files
------------

// File: rtl/d_latch_q4_pkg.sv
// Shared constants for the d_latch_q4 storage primitive.
`timescale 1ns/1ps
package d_latch_q4_pkg;

  localparam int unsigned WIDTH_DEF = 1;

  // Per-bit values forced by the asynchronous clear
  localparam logic Q_RST    = 1'b0;
  localparam logic QBAR_RST = 1'b1;

endpackage

// File: rtl/sr_latch_nand.sv
// One bit of set/reset storage with active-low inputs, modelled on a cross-coupled NAND pair.
`timescale 1ns/1ps
module sr_latch_nand
  import d_latch_q4_pkg::*;
(
  input  logic s_n,
  input  logic r_n,
  output logic q,
  output logic qbar
);

  logic q_l;

  // Reset has priority, so the latch never shows q == qbar when both legs are low
  always_latch begin
    if (!r_n) begin
      q_l <= Q_RST;
    end else if (!s_n) begin
      q_l <= ~Q_RST;
    end
  end

  assign q    = q_l;
  assign qbar = r_n ? ~q_l : QBAR_RST;

endmodule

// File: rtl/d_latch_q4.sv
// Transparent-high D latch with asynchronous active-low clear, WIDTH independent bits.
`timescale 1ns/1ps
module d_latch_q4
  import d_latch_q4_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int          TPD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // TPD only describes timing for simulation; this model switches in zero time
  if (TPD < 0) begin : g_tpd_check
    $error("d_latch_q4: TPD must be non-negative");
  end

  logic [WIDTH-1:0] set_n;
  logic [WIDTH-1:0] rst_leg_n;

  // Gate d and ~d with the enable; the clear joins the reset leg
  assign set_n     = ~(d & {WIDTH{clk}});
  assign rst_leg_n = ~(~d & {WIDTH{clk}}) & {WIDTH{rst_n}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_latch_nand u_sr (
      .s_n  (set_n[i]),
      .r_n  (rst_leg_n[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule

// File: tb/tb_d_latch_q4.sv
// Directed and randomized checks of d_latch_q4 against a timeline-based reference.
`timescale 1ns/1ps
module tb_d_latch_q4;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qbar;

  int n_cmp = 0;
  int n_err = 0;

  d_latch_q4 #(
    .WIDTH (W),
    .TPD   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q),
    .qbar  (qbar)
  );

  // clk is high during [60,120), [180,240), ... and falls at every multiple of 120
  initial begin
    clk = 1'b0;
    forever #60 clk = ~clk;
  end

  task automatic wait_until(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp_q);
    n_cmp++;
    assert (q === exp_q)
    else begin
      n_err++;
      $error("FAIL %s: q=%h expected %h at %0t", tag, q, exp_q, $time);
    end
    n_cmp++;
    assert (qbar === ~exp_q)
    else begin
      n_err++;
      $error("FAIL %s_qbar: qbar=%h expected %h at %0t", tag, qbar, ~exp_q, $time);
    end
  endtask

  function automatic bit clk_high_at(input longint t);
    return (t % 120) >= 60;
  endfunction

  initial begin
    longint       tp;
    longint       t;
    logic [W-1:0] d_prev;
    logic         rst_prev;
    logic [W-1:0] held;
    logic [W-1:0] exp_q;
    logic [W-1:0] d_new;
    logic         rst_new;

    // Clear dominates while clk toggles and d is high
    rst_n = 1'b0;
    d     = '1;
    wait_until(30);   check("rst_clk_low", 8'h00);
    wait_until(90);   check("rst_clk_high", 8'h00);
    // Release while opaque: output stays cleared until the next rise
    wait_until(125);  rst_n = 1'b1;
    wait_until(126);  check("release_low", 8'h00);
    wait_until(140);  d = 8'h00;
    wait_until(150);  d = 8'hFF;
    wait_until(151);  check("opaque_hold", 8'h00);
    wait_until(179);  check("opaque_hold_late", 8'h00);
    wait_until(181);  check("rise_update", 8'hFF);
    wait_until(250);  check("held_after_fall", 8'hFF);
    // d changes at the same instant clk rises
    wait_until(300);  d = 8'h00;
    wait_until(301);  check("rise_coincide", 8'h00);
    wait_until(365);  check("rise_coincide_hold", 8'h00);
    wait_until(415);  check("rise_coincide_hold2", 8'h00);
    // Transparent follow
    wait_until(421);  check("transp_start", 8'h00);
    wait_until(450);  d = 8'hFF;
    wait_until(451);  check("transp_follow1", 8'hFF);
    wait_until(455);  d = 8'h00;
    wait_until(456);  check("transp_follow0", 8'h00);
    wait_until(460);  d = 8'hFF;
    wait_until(461);  check("transp_follow1b", 8'hFF);
    // Mid-phase clear and release while transparent
    wait_until(470);  rst_n = 1'b0;
    wait_until(471);  check("mid_rst", 8'h00);
    wait_until(475);  rst_n = 1'b1;
    wait_until(476);  check("mid_release", 8'hFF);
    // Bus behaviour
    wait_until(550);  d = 8'hA5;
    wait_until(551);  check("bus_transp", 8'hA5);
    wait_until(610);  d = 8'h3C;
    wait_until(611);  check("bus_hold", 8'hA5);
    wait_until(659);  check("bus_hold_late", 8'hA5);
    wait_until(661);  check("bus_next_rise", 8'h3C);

    // Random phase: expectations derived from the clk timeline and the last capture
    wait_until(700);
    tp       = 700;
    d_prev   = d;
    rst_prev = rst_n;
    held     = d;
    for (int k = 0; k < 300; k++) begin
      t = tp + longint'($urandom_range(1, 45));
      // Keep changes and checks clear of clk edges
      while ((t % 60) == 0 || (t % 60) == 59) t++;
      wait_until(t);
      // A fall in (tp, t] captured the d that was stable over that interval
      if ((t / 120) > (tp / 120)) held = rst_prev ? d_prev : '0;
      if (!rst_prev) held = '0;
      d_new   = W'($urandom);
      rst_new = ($urandom_range(0, 9) != 0);
      d       = d_new;
      rst_n   = rst_new;
      #1;
      if (!rst_new) exp_q = '0;
      else if (clk_high_at(t + 1)) exp_q = d_new;
      else exp_q = held;
      check("random", exp_q);
      tp       = t;
      d_prev   = d_new;
      rst_prev = rst_new;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
